// File: rtl/pins_pkg.sv
// Shared types and constants for the pin collision engine and the pins integrator.
// Rack coordinates place the ten pins in the usual triangle at the far end of the lane.
package pins_pkg;

  localparam int NUM_PINS = 10;
  localparam int COORD_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_t;

  typedef logic [NUM_PINS-1:0][COORD_W-1:0] coord_arr_t;

  // Entries are listed from pin 9 down to pin 0.
  localparam coord_arr_t RACK_X = {
    16'd988, 16'd684, 16'd380, 16'd76,
    16'd836, 16'd532, 16'd228,
    16'd684, 16'd380,
    16'd532
  };
  localparam coord_arr_t RACK_Y = {
    16'd19080, 16'd19080, 16'd19080, 16'd19080,
    16'd18816, 16'd18816, 16'd18816,
    16'd18552, 16'd18552,
    16'd18288
  };

  function automatic logic signed [COORD_W-1:0] sat_coord(input logic signed [COORD_W+1:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/pin_contact.sv
// Registered squared-distance compare of one pin against the ball.
// dx/dy are registered alongside the contact flag so the lane update sees matching operands.
module pin_contact
  import pins_pkg::*;
#(
  parameter int HIT_RADIUS = 120
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COORD_W-1:0]        pin_x,
  input  logic [COORD_W-1:0]        pin_y,
  input  logic [COORD_W-1:0]        ball_x,
  input  logic [COORD_W-1:0]        ball_y,
  output logic                      contact,
  output logic signed [COORD_W:0]   dx,
  output logic signed [COORD_W:0]   dy
);

  localparam logic [34:0] R2 = 35'(HIT_RADIUS * HIT_RADIUS);

  logic signed [COORD_W:0] dx_c, dy_c;
  logic signed [34:0]      dx_w, dy_w;
  logic [34:0]             d2;

  always_comb begin
    dx_c = $signed({1'b0, pin_x}) - $signed({1'b0, ball_x});
    dy_c = $signed({1'b0, pin_y}) - $signed({1'b0, ball_y});
    dx_w = {{18{dx_c[COORD_W]}}, dx_c};
    dy_w = {{18{dy_c[COORD_W]}}, dy_c};
    // Each square is below 2^32, so the 35-bit sum is exact.
    d2   = dx_w * dx_w + dy_w * dy_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contact <= 1'b0;
      dx      <= '0;
      dy      <= '0;
    end else begin
      contact <= (d2 <= R2);
      dx      <= dx_c;
      dy      <= dy_c;
    end
  end

endmodule

// File: rtl/pin_collide.sv
// Ball-to-pin collision engine: scans ten pins one per cycle and publishes velocities in EMIT.
// States: IDLE waits for start | SCAN applies pin idx result | EMIT strobes valid_out.
module pin_collide
  import pins_pkg::*;
#(
  parameter int HIT_RADIUS     = 120,
  parameter int TRANSFER_SHIFT = 1
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  input  logic                               clear_in,
  input  logic [COORD_W-1:0]                 ball_x_in,
  input  logic [COORD_W-1:0]                 ball_y_in,
  input  logic signed [COORD_W-1:0]          ball_vx_in,
  input  logic signed [COORD_W-1:0]          ball_vy_in,
  input  logic [NUM_PINS-1:0][COORD_W-1:0]   pins_x_in,
  input  logic [NUM_PINS-1:0][COORD_W-1:0]   pins_y_in,
  output logic                               valid_out,
  output logic [NUM_PINS-1:0][COORD_W-1:0]   pins_vx_out,
  output logic [NUM_PINS-1:0][COORD_W-1:0]   pins_vy_out,
  output logic [NUM_PINS-1:0]                pins_hit_out,
  output logic                               busy_out
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_PINS - 1);

  state_t                    state_q, state_d;
  logic [3:0]                idx_q, iss;
  logic                      rel_q, accept, last;
  logic [COORD_W-1:0]        bx_q, by_q, cx, cy, cbx, cby;
  logic signed [COORD_W-1:0] bvx_q, bvy_q, new_vx, new_vy;
  coord_arr_t                px_q, py_q, w_vx, w_vy, w_vx_d, w_vy_d, vx_q, vy_q;
  logic [NUM_PINS-1:0]       w_hit, w_hit_d, hit_q;
  logic                      contact;
  logic signed [COORD_W:0]   c_dx, c_dy;
  logic signed [COORD_W+1:0] bvx18, bvy18, dx18, dy18;

  // rel_q holds off start for one edge after reset release.
  assign accept = rel_q && (state_q == IDLE) && start_in && !clear_in;
  assign last   = (state_q == SCAN) && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (last) state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_in) state_d = IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= 1'b1;
    end
  end

  // Compare runs one pin ahead of idx; pin 0 is compared from the ports in the accept cycle.
  always_comb begin
    iss = '0;
    if ((state_q == SCAN) && (idx_q != LAST_IDX)) iss = idx_q + 4'd1;
    if (state_q == SCAN) begin
      cx  = px_q[iss];
      cy  = py_q[iss];
      cbx = bx_q;
      cby = by_q;
    end else begin
      cx  = pins_x_in[0];
      cy  = pins_y_in[0];
      cbx = ball_x_in;
      cby = ball_y_in;
    end
  end

  pin_contact #(.HIT_RADIUS(HIT_RADIUS)) u_contact (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .pin_x   (cx),
    .pin_y   (cy),
    .ball_x  (cbx),
    .ball_y  (cby),
    .contact (contact),
    .dx      (c_dx),
    .dy      (c_dy)
  );

  always_comb begin
    bvx18   = {{2{bvx_q[COORD_W-1]}}, bvx_q};
    bvy18   = {{2{bvy_q[COORD_W-1]}}, bvy_q};
    dx18    = {c_dx[COORD_W], c_dx};
    dy18    = {c_dy[COORD_W], c_dy};
    new_vx  = sat_coord((bvx18 >>> TRANSFER_SHIFT) + (dx18 >>> 2));
    new_vy  = sat_coord((bvy18 >>> TRANSFER_SHIFT) + (dy18 >>> 2));
    w_vx_d  = w_vx;
    w_vy_d  = w_vy;
    w_hit_d = w_hit;
    if ((state_q == SCAN) && contact) begin
      w_vx_d[idx_q]  = new_vx;
      w_vy_d[idx_q]  = new_vy;
      w_hit_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q <= '0;
      bx_q  <= '0;
      by_q  <= '0;
      bvx_q <= '0;
      bvy_q <= '0;
      px_q  <= '0;
      py_q  <= '0;
      w_vx  <= '0;
      w_vy  <= '0;
      w_hit <= '0;
      vx_q  <= '0;
      vy_q  <= '0;
      hit_q <= '0;
    end else if (clear_in) begin
      idx_q <= '0;
      w_vx  <= '0;
      w_vy  <= '0;
      w_hit <= '0;
      vx_q  <= '0;
      vy_q  <= '0;
      hit_q <= '0;
    end else begin
      if (accept) begin
        bx_q  <= ball_x_in;
        by_q  <= ball_y_in;
        bvx_q <= ball_vx_in;
        bvy_q <= ball_vy_in;
        px_q  <= pins_x_in;
        py_q  <= pins_y_in;
      end
      if ((state_q == SCAN) && !last) idx_q <= idx_q + 4'd1;
      else idx_q <= '0;
      w_vx  <= w_vx_d;
      w_vy  <= w_vy_d;
      w_hit <= w_hit_d;
      if (last) begin
        vx_q  <= w_vx_d;
        vy_q  <= w_vy_d;
        hit_q <= w_hit_d;
      end
    end
  end

  assign valid_out    = (state_q == EMIT) && !clear_in;
  assign busy_out     = (state_q != IDLE);
  assign pins_vx_out  = vx_q;
  assign pins_vy_out  = vy_q;
  assign pins_hit_out = hit_q;

endmodule

// File: tb/tb_pin_collide.sv
// Directed bench for pin_collide: vector table for contact math plus sequences for control corners.
module tb_pin_collide;
  import pins_pkg::*;

  logic clk = 1'b0;
  logic rst, start, clear;
  logic [15:0] bx, by;
  logic signed [15:0] bvx, bvy;
  logic [9:0][15:0] px, py;
  logic valid, busy, valid0, busy0;
  logic [9:0][15:0] vx, vy, vx0, vy0;
  logic [9:0] hit, hit0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pin_collide dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .clear_in(clear),
    .ball_x_in(bx), .ball_y_in(by), .ball_vx_in(bvx), .ball_vy_in(bvy),
    .pins_x_in(px), .pins_y_in(py), .valid_out(valid),
    .pins_vx_out(vx), .pins_vy_out(vy), .pins_hit_out(hit), .busy_out(busy)
  );

  pin_collide #(.HIT_RADIUS(5000), .TRANSFER_SHIFT(0)) dut0 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .clear_in(clear),
    .ball_x_in(bx), .ball_y_in(by), .ball_vx_in(bvx), .ball_vy_in(bvy),
    .pins_x_in(px), .pins_y_in(py), .valid_out(valid0),
    .pins_vx_out(vx0), .pins_vy_out(vy0), .pins_hit_out(hit0), .busy_out(busy0)
  );

  typedef struct {
    logic [15:0]        bx, by;
    logic signed [15:0] bvx, bvy;
    int                 pin;
    logic [15:0]        px, py;
    logic               hit;
    logic signed [15:0] evx, evy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_pin(input int i, input logic [15:0] x, input logic [15:0] y);
    px    = RACK_X;
    py    = RACK_Y;
    px[i] = x;
    py[i] = y;
  endtask

  task automatic set_ball(input logic [15:0] x, input logic [15:0] y,
                          input logic signed [15:0] vxi, input logic signed [15:0] vyi);
    bx  = x;
    by  = y;
    bvx = vxi;
    bvy = vyi;
  endtask

  // Returns the cycle (start cycle = 0) in which valid_out was seen, capped at 40.
  task automatic do_start(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, nv;
    logic [9:0][15:0] ev_x, ev_y;
    logic [9:0]       eh;

    vecs[0] = '{16'd500,  16'd1000, 16'sd0,     16'sd400,   0, 16'd500,  16'd1000, 1'b1, 16'sd0,    16'sd200};
    vecs[1] = '{16'd500,  16'd1000, 16'sd0,     16'sd400,   3, 16'd620,  16'd1000, 1'b1, 16'sd30,   16'sd200};
    vecs[2] = '{16'd500,  16'd1000, 16'sd0,     16'sd400,   3, 16'd621,  16'd1000, 1'b0, 16'sd0,    16'sd0};
    vecs[3] = '{16'd1000, 16'd1000, -16'sd300,  16'sd100,   5, 16'd930,  16'd1050, 1'b1, -16'sd168, 16'sd62};
    vecs[4] = '{16'd1000, 16'd1000, 16'sd700,   16'sd700,   7, 16'd1085, 16'd1085, 1'b0, 16'sd0,    16'sd0};
    vecs[5] = '{16'd1000, 16'd1000, 16'sd1000,  -16'sd1000, 9, 16'd1084, 16'd1085, 1'b1, 16'sd521,  -16'sd479};
    vecs[6] = '{16'd2000, 16'd3000, -16'sd1,    -16'sd3,    2, 16'd2000, 16'd3000, 1'b1, -16'sd1,   -16'sd2};

    rst = 1'b0; start = 1'b0; clear = 1'b0;
    set_ball(16'd0, 16'd0, 16'sd0, 16'sd0);
    px = RACK_X;
    py = RACK_Y;

    // Start pulsed while held in reset
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("rst valid", 160'(valid), 160'(0));
    chk("rst busy", 160'(busy), 160'(0));
    chk("rst hit", 160'(hit), 160'(0));
    chk("rst vx", 160'(vx), 160'(0));
    chk("rst vy", 160'(vy), 160'(0));
    chk("rst busy0", 160'(busy0), 160'(0));

    // Release: first edge ignores start, second edge accepts it
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk("start first edge after release", 160'(busy), 160'(0));
    tick();
    start = 1'b0;
    chk("start second edge after release", 160'(busy), 160'(1));
    tick();
    pulse_clear();
    chk("clear aborts scan busy", 160'(busy), 160'(0));
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid) nv++;
      tick();
    end
    chk("no valid after clear abort", 160'(nv), 160'(0));

    for (int k = 0; k < 7; k++) begin
      pulse_clear();
      load_pin(vecs[k].pin, vecs[k].px, vecs[k].py);
      set_ball(vecs[k].bx, vecs[k].by, vecs[k].bvx, vecs[k].bvy);
      ev_x = '0;
      ev_y = '0;
      eh   = '0;
      ev_x[vecs[k].pin] = vecs[k].evx;
      ev_y[vecs[k].pin] = vecs[k].evy;
      eh[vecs[k].pin]   = vecs[k].hit;
      do_start(lat);
      chk($sformatf("vec%0d latency", k), 160'(lat), 160'(11));
      chk($sformatf("vec%0d hit", k), 160'(hit), 160'(eh));
      chk($sformatf("vec%0d vx", k), 160'(vx), 160'(ev_x));
      chk($sformatf("vec%0d vy", k), 160'(vy), 160'(ev_y));
      tick();
      chk($sformatf("vec%0d valid one cycle", k), 160'(valid), 160'(0));
    end

    // Restart during SCAN is dropped; exactly one strobe
    pulse_clear();
    load_pin(0, 16'd500, 16'd1000);
    set_ball(16'd500, 16'd1000, 16'sd0, 16'sd400);
    start = 1'b1;
    tick();
    start = 1'b0;
    nv = 0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (valid) nv++;
      tick();
    end
    chk("busy start ignored valid count", 160'(nv), 160'(1));
    ev_y = '0;
    ev_y[0] = 16'd200;
    chk("first run hit", 160'(hit), 160'(10'b0000000001));

    // Ball moved away: lane 0 keeps its sticky state
    set_ball(16'd5000, 16'd5000, 16'sd0, 16'sd400);
    do_start(lat);
    chk("sticky latency", 160'(lat), 160'(11));
    chk("sticky hit", 160'(hit), 160'(10'b0000000001));
    chk("sticky vx", 160'(vx), 160'(0));
    chk("sticky vy", 160'(vy), 160'(ev_y));
    tick();
    pulse_clear();
    chk("clear hit", 160'(hit), 160'(0));
    chk("clear vy", 160'(vy), 160'(0));

    // Clear and start together: clear wins
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("clear beats start", 160'(busy), 160'(0));

    // Clear during EMIT masks the strobe
    set_ball(16'd500, 16'd1000, 16'sd0, 16'sd400);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("emit reached", 160'(valid), 160'(1));
    clear = 1'b1;
    #1;
    chk("clear masks valid", 160'(valid), 160'(0));
    tick();
    clear = 1'b0;
    chk("clear in emit hit", 160'(hit), 160'(0));
    chk("clear in emit busy", 160'(busy), 160'(0));

    // Saturation with TRANSFER_SHIFT = 0, wide radius instance
    pulse_clear();
    load_pin(4, 16'd500, 16'd5000);
    set_ball(16'd500, 16'd1000, 16'sd0, 16'sd32767);
    ev_y = '0;
    ev_y[4] = 16'h7fff;
    do_start(lat);
    chk("sat pos valid0", 160'(valid0), 160'(1));
    chk("sat pos hit0", 160'(hit0), 160'(10'b0000010000));
    chk("sat pos vy0", 160'(vy0), 160'(ev_y));
    chk("sat pos vx0", 160'(vx0), 160'(0));
    tick();
    pulse_clear();
    load_pin(4, 16'd500, 16'd1000);
    set_ball(16'd500, 16'd5000, 16'sd0, -16'sd32768);
    ev_y[4] = 16'h8000;
    do_start(lat);
    chk("sat neg hit0", 160'(hit0), 160'(10'b0000010000));
    chk("sat neg vy0", 160'(vy0), 160'(ev_y));
    tick();

    // Async reset at SCAN index 5
    pulse_clear();
    load_pin(0, 16'd500, 16'd1000);
    set_ball(16'd500, 16'd1000, 16'sd0, 16'sd400);
    do_start(lat);
    tick();
    chk("pre-reset hit", 160'(hit), 160'(10'b0000000001));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre-reset busy", 160'(busy), 160'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("async rst busy", 160'(busy), 160'(0));
    chk("async rst valid", 160'(valid), 160'(0));
    chk("async rst hit", 160'(hit), 160'(0));
    chk("async rst vy", 160'(vy), 160'(0));
    #1;
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) nv++;
    end
    chk("no valid after reset abort", 160'(nv), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
